// File: rtl/result_pkg.sv
// Shared defaults and FSM state type for the result collector.
package result_pkg;
  localparam int DATA_W_DEF = 512;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_e;
endpackage

// File: rtl/result_buffer.sv
// Column storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module result_buffer #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/result_collector.sv
// Collects out-of-order result columns, then drains them in address order.
// Optional duplicate-write flagging via macro RESULT_DUP_CHECK_EN.
module result_collector
  import result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W:0]   NumColumns,
  input  logic              AnsValid,
  input  logic [ADDR_W-1:0] ResultAddress,
  input  logic [DATA_W-1:0] FinalDataOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutAddress,
  output logic [DATA_W-1:0] OutData,
  output logic              Done,
  output logic              ErrRange,
  output logic              ErrDup
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  bitmap_q, bitmap_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              err_range_q, err_range_d;
  logic              we;
`ifdef RESULT_DUP_CHECK_EN
  logic              err_dup_q, err_dup_d;
`endif

  always_comb begin
    state_d     = state_q;
    bitmap_d    = bitmap_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    done_d      = 1'b0;
    err_range_d = err_range_q;
    we          = 1'b0;
`ifdef RESULT_DUP_CHECK_EN
    err_dup_d   = err_dup_q;
`endif
    if (start) begin
      // start wins over everything, including a same-cycle AnsValid
      bitmap_d    = '0;
      fill_d      = '0;
      ptr_d       = '0;
      err_range_d = 1'b0;
`ifdef RESULT_DUP_CHECK_EN
      err_dup_d   = 1'b0;
`endif
      cnt_d       = (NumColumns == '0) ? FULL : NumColumns;
      state_d     = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (AnsValid) begin
            if ({1'b0, ResultAddress} >= cnt_q) begin
              err_range_d = 1'b1;
            end else begin
              we = 1'b1;
              bitmap_d[ResultAddress] = 1'b1;
              if (!bitmap_q[ResultAddress]) fill_d = fill_q + ONE;
`ifdef RESULT_DUP_CHECK_EN
              else err_dup_d = 1'b1;
`endif
            end
          end
          if (fill_q == cnt_q) state_d = DRAIN;
        end
        DRAIN: begin
          if (OutReady) begin
            if ({1'b0, ptr_q} == cnt_q - ONE) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      bitmap_q    <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      done_q      <= 1'b0;
      err_range_q <= 1'b0;
`ifdef RESULT_DUP_CHECK_EN
      err_dup_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitmap_q    <= bitmap_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      done_q      <= done_d;
      err_range_q <= err_range_d;
`ifdef RESULT_DUP_CHECK_EN
      err_dup_q   <= err_dup_d;
`endif
    end
  end

  result_buffer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .CLK    (CLK),
    .we_i   (we),
    .waddr_i(ResultAddress),
    .wdata_i(FinalDataOut),
    .raddr_i(ptr_q),
    .rdata_o(OutData)
  );

  assign OutValid   = (state_q == DRAIN);
  assign OutAddress = ptr_q;
  assign Done       = done_q;
  assign ErrRange   = err_range_q;
`ifdef RESULT_DUP_CHECK_EN
  assign ErrDup     = err_dup_q;
`else
  assign ErrDup     = 1'b0;
`endif
endmodule

// File: tb/tb_result_collector.sv
// Directed sequence with random data against an array/counter model of the collector.
module tb_result_collector;
  localparam int DW = 512;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   NumColumns = '0;
  logic          AnsValid = 1'b0;
  logic [AW-1:0] ResultAddress = '0;
  logic [DW-1:0] FinalDataOut = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [AW-1:0] OutAddress;
  logic [DW-1:0] OutData;
  logic          Done;
  logic          ErrRange;
  logic          ErrDup;

  result_collector dut (
    .CLK(CLK), .RESET(RESET), .start(start), .NumColumns(NumColumns),
    .AnsValid(AnsValid), .ResultAddress(ResultAddress), .FinalDataOut(FinalDataOut),
    .OutValid(OutValid), .OutReady(OutReady), .OutAddress(OutAddress),
    .OutData(OutData), .Done(Done), .ErrRange(ErrRange), .ErrDup(ErrDup)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // reference model
  logic [DW-1:0] m_mem [16];
  bit            m_fill [16];
  int            m_cnt = 0;
  int            m_nfill = 0;
  bit            m_collect = 0;
  bit            m_erange = 0;
  bit            m_edup = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_errrange"}, ErrRange, m_erange);
    chk({tag, "_errdup"}, ErrDup, m_edup);
  endtask

  task automatic tb_start(input int n, input bit av, input int aaddr);
    start = 1'b1;
    NumColumns = (AW + 1)'(n);
    AnsValid = av;
    ResultAddress = AW'(aaddr);
    FinalDataOut = rnd();
    step();
    start = 1'b0;
    AnsValid = 1'b0;
    m_cnt = (n == 0) ? 16 : n;
    m_nfill = 0;
    m_collect = 1;
    m_erange = 0;
    m_edup = 0;
    for (int i = 0; i < 16; i++) m_fill[i] = 0;
    chk_flags("start");
    chk("start_outvalid", OutValid, 0);
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    AnsValid = 1'b1;
    ResultAddress = AW'(addr);
    FinalDataOut = data;
    step();
    AnsValid = 1'b0;
    if (m_collect) begin
      if (addr >= m_cnt) m_erange = 1;
      else begin
        if (m_fill[addr]) begin
`ifdef RESULT_DUP_CHECK_EN
          m_edup = 1;
`endif
        end else begin
          m_fill[addr] = 1;
          m_nfill++;
        end
        m_mem[addr] = data;
      end
    end
    chk_flags("wr");
  endtask

  // called right after the write that completes the set
  task automatic expect_drain();
    chk("pre_drain_outvalid", OutValid, 0);
    step();
    chk("drain_entry_outvalid", OutValid, 1);
    m_collect = 0;
  endtask

  // mode 0: ready held high, 1: toggled 1/0, 2: random
  task automatic drain(input int mode);
    int b = 0;
    int cyc = 0;
    bit r;
    while (b < m_cnt && cyc < 200) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1, 0));
      OutReady = r;
      #1;
      chk("beat_valid", OutValid, 1);
      chk("beat_addr", OutAddress, b);
      chk("beat_data", OutData, m_mem[b]);
      chk("beat_done_low", Done, 0);
      step();
      if (r) b++;
      cyc++;
    end
    chk("drain_beats", b, m_cnt);
    chk("done_pulse", Done, 1);
    chk("post_drain_outvalid", OutValid, 0);
    OutReady = 1'b0;
    step();
    chk("done_cleared", Done, 0);
    chk("idle_outvalid", OutValid, 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_outvalid"}, OutValid, 0);
    chk({tag, "_outaddr"}, OutAddress, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_errrange"}, ErrRange, 0);
    chk({tag, "_errdup"}, ErrDup, 0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    RESET = 1'b1;
    #1;
    chk_cleared(tag);
    m_collect = 0;
    m_erange = 0;
    m_edup = 0;
    m_cnt = 0;
    step();
    RESET = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int perm [16];
    int j;
    int t;
    logic [DW-1:0] d1;

    // reset values
    repeat (2) @(posedge CLK);
    #1;
    chk_cleared("reset");
    RESET = 1'b0;
    step();
    chk_cleared("after_reset");

    // four columns out of order, ready already high before draining
    OutReady = 1'b1;
    tb_start(4, 0, 0);
    wr(3, rnd()); wr(1, rnd()); wr(0, rnd()); wr(2, rnd());
    expect_drain();
    drain(0);

    // NumColumns=0 means 16; shuffled write order, random ready
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    tb_start(0, 0, 0);
    for (int i = 0; i < 16; i++) wr(perm[i], rnd());
    expect_drain();
    drain(2);

    // stalled drain with toggling ready
    tb_start(2, 0, 0);
    wr(1, rnd()); wr(0, rnd());
    expect_drain();
    drain(1);

    // out-of-range and duplicate writes
    tb_start(2, 0, 0);
    d1 = rnd();
    wr(5, rnd());
    wr(0, d1);
    wr(0, rnd());
    wr(1, rnd());
    expect_drain();
    chk("err_range_sticky", ErrRange, 1);
    drain(0);

    // reset mid-collect, then AnsValid while idle must be ignored
    tb_start(4, 0, 0);
    wr(0, rnd()); wr(9, rnd()); wr(1, rnd());
    async_reset("rst_collect");
    wr(3, rnd());
    chk("idle_no_range", ErrRange, 0);
    step();
    chk("idle_outvalid2", OutValid, 0);

    // reset mid-drain
    tb_start(2, 0, 0);
    wr(0, rnd()); wr(1, rnd());
    expect_drain();
    OutReady = 1'b1;
    step();
    chk("mid_drain_addr", OutAddress, 1);
    OutReady = 1'b0;
    async_reset("rst_drain");
    chk("rst_drain_idle", OutValid, 0);

    // restart mid-collect; the AnsValid coinciding with start is dropped
    tb_start(3, 0, 0);
    wr(0, rnd()); wr(1, rnd());
    tb_start(2, 1, 1);
    wr(0, rnd());
    wr(1, rnd());
    expect_drain();
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
